instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 103 ++++++++++
 tb/tb_instr_fetch_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: drives the I-cache fetch PC and buffers {pc, instr} for decode.
// Optional macro FETCHQ_BYPASS_EN forwards a fetch straight to decode when the queue is empty.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic [31:2]              cache_address_o,
  output logic                     cache_req_o,
  input  logic                     cache_blocking_n_i,
  input  logic [31:2]              cache_instr_i,
  input  logic                     branching_i,
  input  logic [31:2]              branch_target_i,
  input  logic                     stall_i,
  output logic                     valid_o,
  output logic [31:2]              instr_o,
  output logic [31:2]              pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [29:0] pc;
    logic [29:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [29:0]     fetch_pc;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            bypass;
  logic            wr_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = !empty && !stall_i && !branching_i;

  // Reset gating keeps the request low while rst_i is held.
  assign cache_req_o     = rst_i && !branching_i && (!full || pop);
  assign cache_address_o = fetch_pc;
  assign push            = cache_req_o && cache_blocking_n_i;

`ifdef FETCHQ_BYPASS_EN
  assign bypass = empty && push && !stall_i;
`else
  assign bypass = 1'b0;
`endif

  assign wr_en   = push && !bypass;
  assign valid_o = !empty || bypass;
  assign count_o = count;

  always_comb begin
    instr_o = '0;
    pc_o    = '0;
    unique case (1'b1)
      bypass: begin
        instr_o = cache_instr_i;
        pc_o    = fetch_pc;
      end
      !empty: begin
        instr_o = mem[rd_ptr].instr;
        pc_o    = mem[rd_ptr].pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (branching_i) begin
      fetch_pc <= branch_target_i;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= '{pc: fetch_pc, instr: cache_instr_i};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push)
        fetch_pc <= fetch_pc + 30'd1;
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: behavioural queue model plus scoreboard.
// Also covers FETCHQ_BYPASS_EN when defined.
module tb_instr_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [29:0] RPC   = 30'h100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [29:0] cache_address_o;
  logic        cache_req_o;
  logic        cache_blocking_n_i;
  logic [29:0] cache_instr_i;
  logic        branching_i;
  logic [29:0] branch_target_i;
  logic        stall_i;
  logic        valid_o;
  logic [29:0] instr_o;
  logic [29:0] pc_o;
  logic [2:0]  count_o;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .cache_address_o    (cache_address_o),
    .cache_req_o        (cache_req_o),
    .cache_blocking_n_i (cache_blocking_n_i),
    .cache_instr_i      (cache_instr_i),
    .branching_i        (branching_i),
    .branch_target_i    (branch_target_i),
    .stall_i            (stall_i),
    .valid_o            (valid_o),
    .instr_o            (instr_o),
    .pc_o               (pc_o),
    .count_o            (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [29:0] pc;
    logic [29:0] instr;
  } ent_t;

  ent_t        sb[$];
  logic [29:0] mpc;
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [29:0] instr_of(input logic [29:0] a);
    return a ^ 30'h15A5_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge: drive, check comb outputs, advance model.
  task automatic cycle(input logic blk, input logic stl,
                       input logic br, input logic [29:0] tgt);
    bit          full, pop, req, push, byp, vld;
    logic [29:0] epc, ein;
    cache_blocking_n_i = blk;
    stall_i            = stl;
    branching_i        = br;
    branch_target_i    = tgt;
    cache_instr_i      = instr_of(mpc);
    #1;
    full = (sb.size() == DEPTH);
    pop  = (sb.size() != 0) && !stl && !br;
    req  = !br && (!full || pop);
    push = req && blk;
    byp  = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    byp  = (sb.size() == 0) && push && !stl;
`endif
    vld = (sb.size() != 0) || byp;
    epc = '0;
    ein = '0;
    if (byp) begin
      epc = mpc;
      ein = instr_of(mpc);
    end else if (sb.size() != 0) begin
      epc = sb[0].pc;
      ein = sb[0].instr;
    end
    check("req",   32'(cache_req_o),     32'(req));
    check("addr",  32'(cache_address_o), 32'(mpc));
    check("count", 32'(count_o),         32'(sb.size()));
    check("valid", 32'(valid_o),         32'(vld));
    check("pc",    32'(pc_o),            32'(epc));
    check("instr", 32'(instr_o),         32'(ein));
    if (br) begin
      sb.delete();
      mpc = tgt;
    end else begin
      if (pop)
        void'(sb.pop_front());
      if (push && !byp)
        sb.push_back('{pc: mpc, instr: instr_of(mpc)});
      if (push)
        mpc = mpc + 30'd1;
    end
    @(negedge clk_i);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req"},   32'(cache_req_o),     32'(0));
    check({tag, "_count"}, 32'(count_o),         32'(0));
    check({tag, "_valid"}, 32'(valid_o),         32'(0));
    check({tag, "_pc"},    32'(pc_o),            32'(0));
    check({tag, "_instr"}, 32'(instr_o),         32'(0));
    check({tag, "_addr"},  32'(cache_address_o), 32'(RPC));
  endtask

  initial begin
    rst_i              = 1'b0;
    cache_blocking_n_i = 1'b1;
    cache_instr_i      = '0;
    branching_i        = 1'b0;
    branch_target_i    = '0;
    stall_i            = 1'b0;
    mpc                = RPC;
    repeat (2) @(negedge clk_i);
    reset_checks("rst");
    rst_i = 1'b1;

    // Stall from reset: queue saturates, fetch parks at RESET_PC+4.
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 1'b1, 1'b0, '0);
    check("sat_count", 32'(count_o),         32'(4));
    check("sat_addr",  32'(cache_address_o), 32'(RPC + 30'd4));
    check("sat_req",   32'(cache_req_o),     32'(0));

    // Full push+pop, then blocking pattern 1,0,0,1.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, 30'h180);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    check("blk_count", 32'(count_o), 32'(2));
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 1'b0, '0);

    // Flush with three entries and a live cache response.
    cycle(1'b1, 1'b0, 1'b1, 30'h180);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 1'b0, '0);
    check("pre_br_count", 32'(count_o), 32'(3));
    cycle(1'b1, 1'b1, 1'b1, 30'h200);
    check("br_count", 32'(count_o),         32'(0));
    check("br_valid", 32'(valid_o),         32'(0));
    check("br_addr",  32'(cache_address_o), 32'(30'h200));
    cycle(1'b1, 1'b0, 1'b0, '0);
`ifndef FETCHQ_BYPASS_EN
    check("br_pc", 32'(pc_o), 32'(30'h200));
`endif
    cycle(1'b1, 1'b0, 1'b0, '0);

    // Two entries, then asynchronous reset mid-cycle.
    cycle(1'b1, 1'b0, 1'b1, 30'h300);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    check("pre_rst_count", 32'(count_o), 32'(2));
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1 reset_checks("arst");
    sb.delete();
    mpc = RPC;
    @(negedge clk_i);
    rst_i = 1'b1;

    // Streaming from reset: PCs 0x100, 0x101, 0x102 back to back.
    cycle(1'b1, 1'b0, 1'b0, '0);
`ifndef FETCHQ_BYPASS_EN
    check("seq0", 32'(pc_o), 32'(RPC));
`endif
    cycle(1'b1, 1'b0, 1'b0, '0);
`ifndef FETCHQ_BYPASS_EN
    check("seq1", 32'(pc_o), 32'(RPC + 30'd1));
`endif
    cycle(1'b1, 1'b0, 1'b0, '0);
`ifndef FETCHQ_BYPASS_EN
    check("seq2", 32'(pc_o), 32'(RPC + 30'd2));
`endif

    // Random mix.
    for (int i = 0; i < 80; i++) begin
      logic br;
      br = ($urandom_range(0, 15) == 0);
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            br, 30'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
